// File: rtl/alu_multibyte_seq.sv
// Byte-serial sequencer that runs NBYTES-wide operations through a shared 8-bit ALU.
// Carry/borrow/shift bits are chained between bytes, and the per-byte zero flags are ANDed together.
module alu_multibyte_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [8*NBYTES-1:0]   i_opa,
  input  logic [8*NBYTES-1:0]   i_opb,
  input  logic                  i_cin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [8*NBYTES-1:0]   o_result,
  output logic                  o_c,
  output logic                  o_z,
  output logic [7:0]            o_alu_a,
  output logic [7:0]            o_alu_b,
  output logic [3:0]            o_alu_sel,
  output logic                  o_alu_cin,
  input  logic [7:0]            i_alu_result,
  input  logic                  i_alu_c,
  input  logic                  i_alu_z
);

  localparam int unsigned IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [3:0]    SEL_IDLE = 4'b1110;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                   r_state;
  op_e                      r_op;
  logic [NBYTES-1:0][7:0]   r_opa;
  logic [NBYTES-1:0][7:0]   r_opb;
  logic [NBYTES-1:0][7:0]   r_work;
  logic [IW-1:0]            r_idx;
  logic                     r_carry;
  logic                     r_zacc;
  logic                     r_busy;
  logic                     r_done;
  logic [8*NBYTES-1:0]      r_result;
  logic                     r_c;
  logic                     r_z;
  logic [7:0]               r_alu_a;
  logic [7:0]               r_alu_b;
  logic [3:0]               r_alu_sel;

  logic [NBYTES-1:0][7:0]   w_opa;
  logic [NBYTES-1:0][7:0]   w_opb;
  logic [NBYTES-1:0][7:0]   w_work;
  op_e                      w_op;
  logic                     w_lsr;
  logic                     w_last;
  logic [IW-1:0]            w_idx_next;
  logic [IW-1:0]            w_start_idx;

  function automatic logic [3:0] sel_of(input op_e op);
    case (op)
      OP_ADD:         sel_of = 4'b0001;
      OP_SUB, OP_CMP: sel_of = 4'b0011;
      OP_AND:         sel_of = 4'b0101;
      OP_OR:          sel_of = 4'b0110;
      OP_XOR:         sel_of = 4'b0111;
      OP_LSL:         sel_of = 4'b1001;
      OP_LSR:         sel_of = 4'b1010;
      default:        sel_of = SEL_IDLE;
    endcase
  endfunction

  assign w_opa       = i_opa;
  assign w_opb       = i_opb;
  assign w_op        = op_e'(i_op);
  assign w_start_idx = (w_op == OP_LSR) ? LAST_IDX : '0;
  assign w_lsr       = (r_op == OP_LSR);
  assign w_last      = w_lsr ? (r_idx == '0) : (r_idx == LAST_IDX);
  assign w_idx_next  = w_lsr ? (r_idx - IW'(1)) : (r_idx + IW'(1));

  // Working result with the byte currently on the ALU merged in
  always_comb begin
    w_work        = r_work;
    w_work[r_idx] = i_alu_result;
  end

  // ALU drive is registered one step ahead so the byte for index k is stable for its whole cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_opa     <= '0;
      r_opb     <= '0;
      r_work    <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_zacc    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= SEL_IDLE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_RUN;
            r_op      <= w_op;
            r_opa     <= w_opa;
            r_opb     <= w_opb;
            r_work    <= '0;
            r_idx     <= w_start_idx;
            r_carry   <= i_cin;
            r_zacc    <= 1'b1;
            r_busy    <= 1'b1;
            r_alu_a   <= w_opa[w_start_idx];
            r_alu_b   <= w_opb[w_start_idx];
            r_alu_sel <= sel_of(w_op);
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_c       <= i_alu_c;
            r_z       <= r_zacc & i_alu_z;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= SEL_IDLE;
            // CMP only reports flags; the previous wide result is kept
            if (r_op != OP_CMP) begin
              r_result <= w_work;
            end
          end else begin
            r_work  <= w_work;
            r_carry <= i_alu_c;
            r_zacc  <= r_zacc & i_alu_z;
            r_idx   <= w_idx_next;
            r_alu_a <= r_opa[w_idx_next];
            r_alu_b <= r_opb[w_idx_next];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_c       = r_c;
  assign o_z       = r_z;
  assign o_alu_a   = r_alu_a;
  assign o_alu_b   = r_alu_b;
  assign o_alu_sel = r_alu_sel;
  assign o_alu_cin = r_carry;

endmodule
